// File: rtl/nanocache_pkg.sv
// nanocache shared types: arbiter FSM states, owner ids, line type.
// Line geometry default matches LINE_WORDS=8.
package nanocache_pkg;

  localparam int NC_LINE_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RD
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR,
    OWN_DATA
  } owner_e;

  typedef logic [NC_LINE_WORDS-1:0][31:0] line_t;

endpackage

// File: rtl/nanocache_rr_pick.sv
// nanocache 2-way picker: round-robin by default, data-priority with
// starvation guard when NANOCACHE_ARB_DATA_PRIO_EN is defined.
module nanocache_rr_pick
  import nanocache_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_req_instr,
  input  logic   i_req_data,
  input  logic   i_take,
  output owner_e o_pick
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef NANOCACHE_ARB_DATA_PRIO_EN

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q;
  logic          starved;

  assign starved = (starve_q >= CW'(STARVE_LIMIT));

  // data wins unless instr has waited through STARVE_LIMIT data grants
  always_comb begin
    o_pick = OWN_DATA;
    if (i_req_instr && (!i_req_data || starved)) begin
      o_pick = OWN_INSTR;
    end
  end

  // consecutive data grants while instr is pending, saturating
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else if (!i_req_instr) begin
      starve_q <= '0;
    end else if (i_take) begin
      if (o_pick == OWN_INSTR) begin
        starve_q <= '0;
      end else if (!starved) begin
        starve_q <= starve_q + CW'(1);
      end
    end
  end

`else

  owner_e last_q;

  // a tie goes to whoever was not granted last
  always_comb begin
    o_pick = OWN_INSTR;
    if (i_req_data && (!i_req_instr || last_q == OWN_INSTR)) begin
      o_pick = OWN_DATA;
    end
  end

  // remember the last winner; reset favours instr on the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= OWN_DATA;
    end else if (i_take) begin
      last_q <= o_pick;
    end
  end

`endif

endmodule

// File: rtl/nanocache_mm_arbiter.sv
// nanocache main-memory line port arbiter (instr read / data read+wb).
// Optional macro: NANOCACHE_ARB_DATA_PRIO_EN (data priority + starve guard).
module nanocache_mm_arbiter
  import nanocache_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WORDS   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_rden_instr,
  input  logic [ADDR_WIDTH-1:0]       i_addr_instr,
  output logic                        o_gnt_instr,
  output logic                        o_rvalid_instr,
  output logic [LINE_WORDS-1:0][31:0] o_rdata_instr,
  input  logic                        i_rden_data,
  input  logic                        i_wren_data,
  input  logic [ADDR_WIDTH-1:0]       i_addr_data,
  input  logic [LINE_WORDS-1:0][31:0] i_wdata_data,
  output logic                        o_gnt_data,
  output logic                        o_rvalid_data,
  output logic [LINE_WORDS-1:0][31:0] o_rdata_data,
  output logic                        o_mm_rden,
  output logic                        o_mm_wren,
  output logic [ADDR_WIDTH-1:0]       o_mm_addr,
  output logic [LINE_WORDS-1:0][31:0] o_mm_wdata,
  input  logic                        i_mm_gnt,
  input  logic [LINE_WORDS-1:0][31:0] i_mm_rdata,
  input  logic                        i_mm_rvalid
);

  arb_state_e state_q;
  owner_e     owner_q;
  owner_e     pick;
  logic       rd_q;
  logic       req_data;
  logic       take;
  logic       gnt_fire;
  logic       rsp_fire;

  assign req_data = i_rden_data | i_wren_data;
  assign take     = (state_q == IDLE) & (i_rden_instr | req_data);

  nanocache_rr_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req_instr(i_rden_instr),
    .i_req_data (req_data),
    .i_take     (take),
    .o_pick     (pick)
  );

  // one outstanding transaction; memory-side command is registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_INSTR;
      rd_q       <= 1'b0;
      o_mm_rden  <= 1'b0;
      o_mm_wren  <= 1'b0;
      o_mm_addr  <= '0;
      o_mm_wdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            owner_q <= pick;
            state_q <= REQ;
            if (pick == OWN_DATA) begin
              o_mm_wren  <= i_wren_data;
              o_mm_rden  <= ~i_wren_data;
              o_mm_addr  <= i_addr_data;
              o_mm_wdata <= i_wdata_data;
              rd_q       <= ~i_wren_data;
            end else begin
              o_mm_wren  <= 1'b0;
              o_mm_rden  <= 1'b1;
              o_mm_addr  <= i_addr_instr;
              o_mm_wdata <= '0;
              rd_q       <= 1'b1;
            end
          end
        end
        REQ: begin
          if (i_mm_gnt) begin
            o_mm_rden <= 1'b0;
            o_mm_wren <= 1'b0;
            if (!rd_q || i_mm_rvalid) begin
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (i_mm_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // grant and response steering back to the current owner
  always_comb begin
    gnt_fire = i_mm_gnt & (state_q == REQ);
    rsp_fire = i_mm_rvalid & rd_q &
               ((state_q == WAIT_RD) | gnt_fire);
    o_gnt_instr    = gnt_fire & (owner_q == OWN_INSTR);
    o_gnt_data     = gnt_fire & (owner_q == OWN_DATA);
    o_rvalid_instr = rsp_fire & (owner_q == OWN_INSTR);
    o_rvalid_data  = rsp_fire & (owner_q == OWN_DATA);
  end

  assign o_rdata_instr = i_mm_rdata;
  assign o_rdata_data  = i_mm_rdata;

  a_instr_hold: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (i_rden_instr && !o_gnt_instr) |=>
      (i_rden_instr && $stable(i_addr_instr))
  ) else $error("instr request dropped or changed before grant");

  a_data_hold: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (req_data && !o_gnt_data) |=>
      ($stable(i_rden_data) && $stable(i_wren_data) &&
       $stable(i_addr_data) && $stable(i_wdata_data))
  ) else $error("data request dropped or changed before grant");

  a_data_excl: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_rden_data && i_wren_data)
  ) else $error("data read and write-back requested together");

endmodule

// File: doc/nanocache_mm_arbiter.md
Name: nanocache_mm_arbiter

Overview:
- Shares one main-memory line port (8x32b line, read/write) between the instruction-cache update engine and the data-cache update engine.
- The instruction engine is read-only; the data engine issues line reads and write-backs.
- Sits between the two cache update instances and the SRAM/memory controller.
- Serialises transactions with one outstanding transaction at a time, arbitrates round-robin, and routes grant/response back to the owner.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- LINE_WORDS, 8, 32-bit words per line; line width = 32*LINE_WORDS.
- STARVE_LIMIT, 4, max consecutive grants to one requester while the other is pending (used only with NANOCACHE_ARB_DATA_PRIO_EN).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rden_instr  in  1  instr line-read request
- i_addr_instr  in  ADDR_WIDTH  instr line address
- o_gnt_instr  out  1  instr request accepted by memory
- o_rvalid_instr  out  1  instr read data valid
- o_rdata_instr  out  [LINE_WORDS-1:0][31:0]  instr read line
- i_rden_data  in  1  data line-read request
- i_wren_data  in  1  data line write-back request
- i_addr_data  in  ADDR_WIDTH  data line address
- i_wdata_data  in  [LINE_WORDS-1:0][31:0]  write-back line
- o_gnt_data  out  1  data request accepted
- o_rvalid_data  out  1  data read data valid
- o_rdata_data  out  [LINE_WORDS-1:0][31:0]  data read line
- o_mm_rden  out  1  memory read request
- o_mm_wren  out  1  memory write request
- o_mm_addr  out  ADDR_WIDTH  memory address
- o_mm_wdata  out  [LINE_WORDS-1:0][31:0]  memory write line
- i_mm_gnt  in  1  memory accepted request
- i_mm_rdata  in  [LINE_WORDS-1:0][31:0]  memory read line
- i_mm_rvalid  in  1  memory read data valid

Behaviour:
- Reset: state IDLE; owner=INSTR; last-granted=DATA (so instr wins first tie). o_mm_rden, o_mm_wren, o_mm_addr, o_mm_wdata, o_gnt_*, o_rvalid_* all 0. Reset mid-transaction aborts silently; the memory side must also be reset.
- Requester rule: a request stays asserted, with stable addr/wdata, until its o_gnt pulse; deasserting earlier is illegal (checked by assertion).
- Data requester: i_rden_data and i_wren_data together is illegal; the arbiter services the write first and ignores rden.
- FSM:
  - IDLE: if any request, pick owner (round-robin: the requester not last granted wins a tie). Register o_mm_rden/o_mm_wren/o_mm_addr/o_mm_wdata from the owner. -> REQ. Memory request is visible one cycle after the request is sampled.
  - REQ: hold the memory outputs. On i_mm_gnt: drop o_mm_rden/o_mm_wren the next cycle. Write -> IDLE. Read -> WAIT_RD, unless i_mm_rvalid is high in the same cycle, in which case deliver the response and go -> IDLE.
  - WAIT_RD: on i_mm_rvalid -> IDLE.
- o_gnt_x = i_mm_gnt & state==REQ & owner==x (combinational, single-cycle pulse).
- o_rvalid_x = i_mm_rvalid & (state==WAIT_RD | (state==REQ & i_mm_gnt)) & owner==x & read.
- o_rdata_instr and o_rdata_data are both wired to i_mm_rdata. Qualify with rvalid.
- i_mm_rvalid outside a read transaction is ignored.
- Back-to-back: IDLE lasts at least one cycle between transactions. A new request sampled in IDLE is issued the following cycle.

Optional Feature:
- Macro: NANOCACHE_ARB_DATA_PRIO_EN.
- Defined: fixed priority to the data requester. A saturating counter counts consecutive data grants while instr is pending. When the count reaches STARVE_LIMIT, instr wins the next arbitration and the counter clears. The counter also clears on any instr grant or when instr is idle.
- Undefined: pure round-robin; no counter logic.

Decomposition:
- Package nanocache_pkg: arb_state_e {IDLE, REQ, WAIT_RD}; owner_e {OWN_INSTR, OWN_DATA}; line_t = logic [LINE_WORDS-1:0][31:0].
- Sub-module nanocache_rr_pick: 2-way round-robin/priority picker with last-grant register and starvation counter. Everything else stays in the top FSM.

Test Plan:
- Single instr read at 0x100; mm gnt after 2 cycles, rvalid after 3 more -> o_mm_addr=0x100, one o_gnt_instr pulse, o_rvalid_instr with line 0x0..0x7; data outputs stay 0.
- Simultaneous instr read 0x200 and data read 0x300 after reset -> instr serviced first, then data. Both complete with correct rdata routing and no overlap on the mm port.
- Data write-back 0x400 with wdata word[i]=0xA0+i -> o_mm_wren=1 with that line; o_gnt_data on i_mm_gnt; no rvalid expected; return to IDLE.
- Zero-latency memory (gnt and rvalid same cycle) on instr read -> o_gnt_instr and o_rvalid_instr pulse in the same cycle; FSM goes REQ->IDLE.
- NANOCACHE_ARB_DATA_PRIO_EN, STARVE_LIMIT=4, data requests continuous, instr pending -> exactly 4 data grants, then 1 instr grant, repeating.
- Reset asserted in WAIT_RD -> all outputs 0 immediately; a late i_mm_rvalid after release produces no o_rvalid_*.
